// File: rtl/clk_ref_lock_mon_if.sv
// clk_ref_lock_mon_if: config/status bus between the register map (master) and the lock monitor (slave)
interface clk_ref_lock_mon_if #(
  parameter int NCH = 2,
  parameter int CW  = 21
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  logic [NCH-1:0]    cfg_en_i;
  logic [CW-1:0]     cfg_lo_i;
  logic [CW-1:0]     cfg_hi_i;
  logic              cfg_revert_i;
  logic [NCH-1:0]    clr_loss_i;
  logic [NCH*CW-1:0] meas_o;
  logic [NCH-1:0]    meas_vld_o;
  logic [NCH-1:0]    sts_lock_o;
  logic [NCH-1:0]    sts_loss_o;
  logic [SW-1:0]     sel_o;
  logic              sel_vld_o;
  modport master (
    output cfg_en_i, cfg_lo_i, cfg_hi_i, cfg_revert_i, clr_loss_i,
    input  meas_o, meas_vld_o, sts_lock_o, sts_loss_o, sel_o, sel_vld_o
  );
  modport slave (
    input  cfg_en_i, cfg_lo_i, cfg_hi_i, cfg_revert_i, clr_loss_i,
    output meas_o, meas_vld_o, sts_lock_o, sts_loss_o, sel_o, sel_vld_o
  );
endinterface

// File: rtl/clk_ref_lock_mon.sv
// clk_ref_lock_mon: per-channel ref-clock period measurement, lock/slip filtering, sticky loss and active-reference select
module clk_ref_lock_mon #(
  parameter int NCH      = 2,
  parameter int CW       = 21,
  parameter int DIV_LOG2 = 14,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2
) (
  input logic           clk_i,
  input logic           pll_ff_rst,
  input logic [NCH-1:0] ref_clk_i,
  clk_ref_lock_mon_if.slave bus
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(UNLOCK_N + 1);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, SLIP} state_e;
  logic [NCH-1:0] lock_w;
  logic [SW-1:0]  sel_q, sel_d, low_w;
  logic           sel_vld_q, any_w;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIV_LOG2-1:0] div_q;
    logic [2:0]          s_q;
    logic [CW-1:0]       cnt_q, meas_q;
    logic [GW-1:0]       g_q;
    logic [MW-1:0]       m_q;
    state_e              st_q;
    logic                vld_q, lock_q, loss_q;
    logic                edge_w, evt_w, good_w, bad_w, lose_w;
    always_ff @(posedge ref_clk_i[k] or negedge pll_ff_rst)
      if (!pll_ff_rst) div_q <= '0;
      else div_q <= div_q + DIV_LOG2'(1);
    assign edge_w = s_q[2] ^ s_q[1];
    // a saturated counter with no edge is a timeout and always counts as a bad event
    assign evt_w  = edge_w | (&cnt_q);
    assign good_w = edge_w && cnt_q >= bus.cfg_lo_i && cnt_q <= bus.cfg_hi_i;
    assign bad_w  = evt_w && !good_w;
    assign lose_w = bus.cfg_en_i[k] && bad_w &&
                    ((st_q == LOCKED && UNLOCK_N == 1) || (st_q == SLIP && m_q == MW'(UNLOCK_N - 1)));
    always_ff @(posedge clk_i or negedge pll_ff_rst)
      if (!pll_ff_rst) begin
        s_q    <= '0;
        cnt_q  <= '0;
        meas_q <= '0;
        vld_q  <= 1'b0;
        g_q    <= '0;
        m_q    <= '0;
        st_q   <= IDLE;
        lock_q <= 1'b0;
        loss_q <= 1'b0;
      end else begin
        s_q    <= {s_q[1:0], div_q[DIV_LOG2-1]};
        cnt_q  <= evt_w ? CW'(1) : cnt_q + CW'(1);
        vld_q  <= evt_w;
        loss_q <= lose_w | (loss_q & ~bus.clr_loss_i[k]);
        if (evt_w) meas_q <= edge_w ? cnt_q : '1;
        if (!bus.cfg_en_i[k]) begin
          st_q   <= IDLE;
          g_q    <= '0;
          m_q    <= '0;
          lock_q <= 1'b0;
        end else begin
          case (st_q)
            IDLE: st_q <= ACQ;
            ACQ: if (evt_w) begin
              if (!good_w) g_q <= '0;
              else if (g_q == GW'(LOCK_N - 1)) begin
                g_q    <= '0;
                st_q   <= LOCKED;
                lock_q <= 1'b1;
              end else g_q <= g_q + GW'(1);
            end
            LOCKED: if (bad_w) begin
              if (UNLOCK_N == 1) begin
                st_q   <= ACQ;
                lock_q <= 1'b0;
              end else begin
                st_q <= SLIP;
                m_q  <= MW'(1);
              end
            end
            default: if (evt_w) begin
              if (good_w) begin
                st_q <= LOCKED;
                m_q  <= '0;
              end else if (m_q == MW'(UNLOCK_N - 1)) begin
                st_q   <= ACQ;
                m_q    <= '0;
                lock_q <= 1'b0;
              end else m_q <= m_q + MW'(1);
            end
          endcase
        end
      end
    assign lock_w[k]                = lock_q;
    assign bus.meas_o[k*CW +: CW]   = meas_q;
    assign bus.meas_vld_o[k]        = vld_q;
    assign bus.sts_loss_o[k]        = loss_q;
  end
  always_comb begin
    low_w = '0;
    for (int i = NCH - 1; i >= 0; i--) if (lock_w[i]) low_w = SW'(i);
  end
  assign any_w = |lock_w;
  // non-revertive mode only moves off the current reference once it drops lock
  assign sel_d = any_w && (bus.cfg_revert_i || !lock_w[sel_q]) ? low_w : sel_q;
  always_ff @(posedge clk_i or negedge pll_ff_rst)
    if (!pll_ff_rst) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_vld_q <= any_w;
    end
  assign bus.sts_lock_o = lock_w;
  assign bus.sel_o      = sel_q;
  assign bus.sel_vld_o  = sel_vld_q;
endmodule

// File: tb/tb_clk_ref_lock_mon.sv
// tb_clk_ref_lock_mon: directed checks of measurement, lock/slip/loss filtering, select and reset
module tb_clk_ref_lock_mon;
  logic clk = 1'b0, pll_ff_rst = 1'b0, ref0 = 1'b0, ref1 = 1'b0;
  int   hp0 = 50, hp1 = 50;
  bit   run0 = 1'b1, run1 = 1'b0;
  int   n_run = 0, n_fail = 0;
  clk_ref_lock_mon_if #(.NCH(2), .CW(8)) bus ();
  clk_ref_lock_mon #(.NCH(2), .CW(8), .DIV_LOG2(4), .LOCK_N(4), .UNLOCK_N(2)) dut (
    .clk_i(clk), .pll_ff_rst(pll_ff_rst), .ref_clk_i({ref1, ref0}), .bus(bus)
  );
  always #4 clk = ~clk;
  // ref edges stay on odd time steps so they never coincide with a clk edge
  initial begin #3; forever begin #(hp0); if (run0) ref0 = ~ref0; end end
  initial begin #5; forever begin #(hp1); if (run1) ref1 = ~ref1; end end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_vld(input int k, input int lim, output logic [7:0] m, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.meas_vld_o[k] && n < lim);
    if (!bus.meas_vld_o[k]) chk($sformatf("vld_timeout_ch%0d", k), {31'd0, bus.meas_vld_o[k]}, 1);
    m = bus.meas_o[k*8 +: 8];
  endtask
  task automatic acquire(input int k, input string tag);
    logic [7:0] m;
    int n, g;
    g = 0;
    for (int i = 0; i < 12 && g < 4; i++) begin
      wait_vld(k, 300, m, n);
      g = (m >= 98 && m <= 102) ? g + 1 : 0;
      chk($sformatf("%s_lock%0d", tag, i), {31'd0, bus.sts_lock_o[k]}, (g >= 4) ? 1 : 0);
    end
    if (g < 4) chk({tag, "_never_locked"}, {31'd0, bus.sts_lock_o[k]}, 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_meas"}, {16'd0, bus.meas_o}, 0);
    chk({tag, "_vld"}, {30'd0, bus.meas_vld_o}, 0);
    chk({tag, "_lock"}, {30'd0, bus.sts_lock_o}, 0);
    chk({tag, "_loss"}, {30'd0, bus.sts_loss_o}, 0);
    chk({tag, "_sel"}, {31'd0, bus.sel_o}, 0);
    chk({tag, "_selvld"}, {31'd0, bus.sel_vld_o}, 0);
  endtask
  initial begin
    logic [7:0] m;
    int n;
    bus.cfg_en_i = 2'b00; bus.cfg_lo_i = 8'd98; bus.cfg_hi_i = 8'd102;
    bus.cfg_revert_i = 1'b0; bus.clr_loss_i = 2'b00;
    repeat (5) @(negedge clk);
    chk_reset("rst");
    pll_ff_rst = 1'b1;
    bus.cfg_en_i = 2'b01;
    acquire(0, "t1");
    chk("t1_selvld_lag", {31'd0, bus.sel_vld_o}, 0);
    @(negedge clk);
    chk("t1_selvld", {31'd0, bus.sel_vld_o}, 1);
    chk("t1_sel", {31'd0, bus.sel_o}, 0);
    hp0 = 60;
    wait_vld(0, 300, m, n);
    chk("t5_bad_meas", {31'd0, m > 8'd102}, 1);
    chk("t5_slip_lock", {31'd0, bus.sts_lock_o[0]}, 1);
    chk("t5_slip_loss", {31'd0, bus.sts_loss_o[0]}, 0);
    hp0 = 50;
    wait_vld(0, 300, m, n);
    chk("t5_good_meas", {31'd0, m >= 8'd98 && m <= 8'd102}, 1);
    chk("t5_relock", {31'd0, bus.sts_lock_o[0]}, 1);
    chk("t5_noloss", {31'd0, bus.sts_loss_o[0]}, 0);
    wait_vld(0, 300, m, n);
    chk("t5_meas100", {24'd0, m}, 100);
    chk("t5_gap100", n, 100);
    hp0 = 56;
    wait_vld(0, 300, m, n);
    chk("t2_bad1_meas", {31'd0, m > 8'd102}, 1);
    chk("t2_slip_lock", {31'd0, bus.sts_lock_o[0]}, 1);
    chk("t2_slip_loss", {31'd0, bus.sts_loss_o[0]}, 0);
    wait_vld(0, 300, m, n);
    chk("t2_meas112", {24'd0, m}, 112);
    chk("t2_unlock", {31'd0, bus.sts_lock_o[0]}, 0);
    chk("t2_loss", {31'd0, bus.sts_loss_o[0]}, 1);
    @(negedge clk);
    chk("t2_selvld", {31'd0, bus.sel_vld_o}, 0);
    chk("t2_sel_hold", {31'd0, bus.sel_o}, 0);
    bus.clr_loss_i = 2'b01;
    @(negedge clk);
    bus.clr_loss_i = 2'b00;
    chk("t2_clr", {31'd0, bus.sts_loss_o[0]}, 0);
    hp0 = 50;
    acquire(0, "t2r");
    run0 = 1'b0;
    wait_vld(0, 300, m, n);
    chk("t3_to1_gap", n, 255);
    chk("t3_to1_meas", {24'd0, m}, 255);
    chk("t3_to1_lock", {31'd0, bus.sts_lock_o[0]}, 1);
    chk("t3_to1_loss", {31'd0, bus.sts_loss_o[0]}, 0);
    repeat (254) @(negedge clk);
    bus.clr_loss_i = 2'b01;
    @(negedge clk);
    bus.clr_loss_i = 2'b00;
    chk("t3_to2_vld", {31'd0, bus.meas_vld_o[0]}, 1);
    chk("t3_to2_meas", {24'd0, bus.meas_o[7:0]}, 255);
    chk("t3_to2_lock", {31'd0, bus.sts_lock_o[0]}, 0);
    chk("t3_set_wins", {31'd0, bus.sts_loss_o[0]}, 1);
    bus.clr_loss_i = 2'b01;
    @(negedge clk);
    bus.clr_loss_i = 2'b00;
    chk("t3_clr", {31'd0, bus.sts_loss_o[0]}, 0);
    run1 = 1'b1;
    bus.cfg_en_i = 2'b11;
    acquire(1, "t4a");
    @(negedge clk);
    chk("t4_sel1", {31'd0, bus.sel_o}, 1);
    chk("t4_selvld", {31'd0, bus.sel_vld_o}, 1);
    run0 = 1'b1;
    acquire(0, "t4b");
    @(negedge clk);
    chk("t4_keep", {31'd0, bus.sel_o}, 1);
    bus.cfg_revert_i = 1'b1;
    @(negedge clk);
    chk("t4_revert", {31'd0, bus.sel_o}, 0);
    bus.cfg_revert_i = 1'b0;
    bus.cfg_en_i = 2'b10;
    @(negedge clk);
    chk("dis_lock", {31'd0, bus.sts_lock_o[0]}, 0);
    chk("dis_noloss", {31'd0, bus.sts_loss_o[0]}, 0);
    chk("dis_sel_lag", {31'd0, bus.sel_o}, 0);
    @(negedge clk);
    chk("dis_sel", {31'd0, bus.sel_o}, 1);
    chk("dis_selvld", {31'd0, bus.sel_vld_o}, 1);
    bus.cfg_lo_i = 8'd102; bus.cfg_hi_i = 8'd98;
    wait_vld(1, 300, m, n);
    chk("win_meas", {24'd0, m}, 100);
    chk("win_slip", {31'd0, bus.sts_lock_o[1]}, 1);
    wait_vld(1, 300, m, n);
    chk("win_unlock", {31'd0, bus.sts_lock_o[1]}, 0);
    chk("win_loss", {31'd0, bus.sts_loss_o[1]}, 1);
    @(negedge clk);
    chk("win_selvld", {31'd0, bus.sel_vld_o}, 0);
    chk("win_sel_hold", {31'd0, bus.sel_o}, 1);
    bus.cfg_lo_i = 8'd98; bus.cfg_hi_i = 8'd102;
    bus.cfg_en_i = 2'b00;
    wait_vld(0, 300, m, n);
    bus.cfg_en_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      wait_vld(0, 300, m, n);
      chk($sformatf("t6_acq%0d", i), {31'd0, bus.sts_lock_o[0]}, 0);
    end
    pll_ff_rst = 1'b0;
    #1;
    chk_reset("t6_rst");
    repeat (3) @(negedge clk);
    pll_ff_rst = 1'b1;
    acquire(0, "t6");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
